mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Initiator side of the single-port-pair memory handshake (w_en/r_en pulses in, r_rdy/w_rdy back, registered r_data).
- Accepts read/write commands from a client over a valid/ready interface and issues exactly one one-cycle enable pulse per command to the memory.
- Waits for the matching ready, then returns a response (read data or write ack) on a valid/ready response channel.
- Covers memory initialization after reset and a bounded wait with timeout error.

Parameters:
WORD_SIZE, 8, data width; must match memory
ADDRESS_SIZE, 4, address width; must match memory
INIT_CYCLES, 64, cycles after reset before first command accepted; must be at least the memory's init duration
TIMEOUT, 15, max cycles spent in a WAIT state before error
TIMER_SIZE, 7, counter width; must hold max(INIT_CYCLES, TIMEOUT)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  client command present
cmd_ready  out  1  block accepts command this cycle
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDRESS_SIZE  command address
cmd_wdata  in  WORD_SIZE  write data
rsp_valid  out  1  response present
rsp_ready  in  1  client takes response
rsp_write  out  1  response belongs to a write
rsp_data  out  WORD_SIZE  read data (0 for writes/errors)
rsp_err  out  1  command timed out
timeout_flag  out  1  sticky: any timeout since reset
w_en  out  1  write enable pulse to memory
r_en  out  1  read enable pulse to memory
w_addr  out  ADDRESS_SIZE  memory write address
r_addr  out  ADDRESS_SIZE  memory read address
w_data  out  WORD_SIZE  memory write data
r_data  in  WORD_SIZE  memory read data
r_rdy  in  1  memory read complete, one-cycle pulse
w_rdy  in  1  memory write complete, level; cleared by memory on w_en

Behaviour:
- Reset (reset==0 at an edge):
  - state=INIT, timer=INIT_CYCLES.
  - All outputs 0: cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_err, timeout_flag, w_en, r_en, addresses, w_data.
- INIT: timer decrements each cycle; at 0 -> IDLE. r_rdy/w_rdy ignored.
- IDLE:
  - cmd_ready=1 (registered; asserted on the cycle after entering IDLE).
  - On cmd_valid&cmd_ready at edge T, the block registers the address/data into r_addr or w_addr/w_data, sets r_en or w_en=1, sets cmd_ready=0, and moves to ISSUE.
- ISSUE (one cycle):
  - Enable back to 0 at edge T+1; timer=TIMEOUT; state -> WAIT.
  - Ready inputs are not sampled here; this masks a stale-high w_rdy.
- WAIT (from edge T+2):
  - Read: r_rdy==1 -> capture r_data into rsp_data, rsp_valid=1, rsp_write=0, rsp_err=0 -> RESP.
  - Write: w_rdy==1 -> rsp_valid=1, rsp_write=1, rsp_data=0 -> RESP.
  - Ready absent: timer decrements. Timer==0 with no ready -> rsp_valid=1, rsp_err=1, rsp_data=0, timeout_flag=1 -> RESP.
  - Only the ready matching the outstanding type counts.
- RESP:
  - Outputs held stable until rsp_valid&rsp_ready.
  - Then rsp_valid=0, rsp_err=0 -> IDLE. cmd_ready returns 1 one cycle later (no same-cycle re-accept).
- Latency, acceptance edge to rsp_valid visible:
  - read: READ_WAIT+3 cycles
  - write: WRITE_WAIT+3 cycles
- Exactly one outstanding command; the enable is never held more than one cycle, since the memory relatches r_data every r_en cycle.
- Addresses and w_data are held after the pulse until the next accept.
- The timer decrement saturates at 0. timeout_flag clears only on reset.
- Reset mid-transaction: pending command dropped, no response, INIT restarts. The client must reset the memory in the same cycle.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding (INIT, IDLE, ISSUE, WAIT, RESP)
  - OFF/ON constants
  - WORD_SIZE/ADDRESS_SIZE defaults shared with memory
- No sub-module. The single down-counter is shared by INIT and WAIT.

Test Plan:
- Reset, hold cmd_valid=1 -> cmd_ready stays 0 for INIT_CYCLES cycles, then rises; all outputs 0 during reset.
- With memory (READ_WAIT=0), write addr 3 data 0xA5, then read addr 3 -> write rsp after 3 cycles with rsp_write=1; read rsp_data=0xA5 after 3 cycles; w_en/r_en each high for exactly 1 cycle.
- Write, then immediately a second write to addr 4 while memory w_rdy is still high from the first -> second rsp is not early; it arrives at exactly WRITE_WAIT+3 cycles.
- Tie r_rdy=0, issue read -> rsp_err=1, rsp_data=0 after TIMEOUT+2 cycles; timeout_flag=1 and stays 1 after later good commands.
- Hold rsp_ready=0 for 5 cycles on a read response -> rsp_valid/rsp_data stable; cmd_ready=0 throughout; first new accept no sooner than 1 cycle after the rsp handshake.
- Assert reset=0 during WAIT of a read -> no response emitted; block returns to INIT; outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory initiator and the memory it drives.
// Holds the FSM state encoding, OFF/ON constants and the default word and
// address widths, which must agree between initiator and memory.
package mem_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE    = 8;
    localparam int unsigned DEFAULT_ADDRESS_SIZE = 4;

    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mem_initiator_if.sv
// Bundle of the client command/response channels and the memory handshake.
// master: initiator side (drives cmd_ready, rsp_*, timeout_flag, enables,
//         addresses and write data; receives commands, rsp_ready and the
//         memory's r_data/r_rdy/w_rdy).
// slave:  client plus memory side, the mirror image.
interface mem_initiator_if
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE
) ();

    // client command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDRESS_SIZE-1:0] cmd_addr;
    logic [WORD_SIZE-1:0]    cmd_wdata;

    // client response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_write;
    logic [WORD_SIZE-1:0]    rsp_data;
    logic                    rsp_err;
    logic                    timeout_flag;

    // memory port pair
    logic                    w_en;
    logic                    r_en;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [WORD_SIZE-1:0]    w_data;
    logic [WORD_SIZE-1:0]    r_data;
    logic                    r_rdy;
    logic                    w_rdy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, r_data, r_rdy, w_rdy,
        output cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_err, timeout_flag,
        output w_en, r_en, w_addr, r_addr, w_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, r_data, r_rdy, w_rdy,
        input  cmd_ready, rsp_valid, rsp_write, rsp_data, rsp_err, timeout_flag,
        input  w_en, r_en, w_addr, r_addr, w_data
    );

endinterface

// File: rtl/mem_initiator.sv
// Memory initiator: accepts one read/write command at a time from a client,
// issues a single one-cycle enable pulse to the memory, waits (bounded) for
// the matching ready and returns read data, a write ack or a timeout error.
// Ports:
//   clock - rising-edge system clock
//   reset - synchronous, active-low reset
//   bus   - mem_initiator_if.master: command, response and memory signals
// All outputs are registered.
module mem_initiator
    import mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int unsigned ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int unsigned INIT_CYCLES  = 64,
    parameter int unsigned TIMEOUT      = 15,
    parameter int unsigned TIMER_SIZE   = 7
) (
    input logic             clock,
    input logic             reset,
    mem_initiator_if.master bus
);

    localparam logic [TIMER_SIZE-1:0] INIT_LOAD    = TIMER_SIZE'(INIT_CYCLES);
    localparam logic [TIMER_SIZE-1:0] TIMEOUT_LOAD = TIMER_SIZE'(TIMEOUT);
    localparam logic [TIMER_SIZE-1:0] TIMER_ONE    = TIMER_SIZE'(1);

    state_e                  state_q, state_d;
    logic [TIMER_SIZE-1:0]   timer_q, timer_d;
    logic                    op_write_q, op_write_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [WORD_SIZE-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    timeout_flag_q, timeout_flag_d;
    logic                    w_en_q, w_en_d;
    logic                    r_en_q, r_en_d;
    logic [ADDRESS_SIZE-1:0] w_addr_q, w_addr_d;
    logic [ADDRESS_SIZE-1:0] r_addr_q, r_addr_d;
    logic [WORD_SIZE-1:0]    w_data_q, w_data_d;

    logic accept;
    logic ready_hit;
    logic timer_zero;

    assign accept     = bus.cmd_valid && cmd_ready_q;
    // Only the ready belonging to the outstanding command type counts.
    assign ready_hit  = op_write_q ? bus.w_rdy : bus.r_rdy;
    assign timer_zero = (timer_q == '0);

    // State register and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= StInit;
            timer_q        <= INIT_LOAD;
            op_write_q     <= OFF;
            cmd_ready_q    <= OFF;
            rsp_valid_q    <= OFF;
            rsp_write_q    <= OFF;
            rsp_data_q     <= '0;
            rsp_err_q      <= OFF;
            timeout_flag_q <= OFF;
            w_en_q         <= OFF;
            r_en_q         <= OFF;
            w_addr_q       <= '0;
            r_addr_q       <= '0;
            w_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            op_write_q     <= op_write_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_write_q    <= rsp_write_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            timeout_flag_q <= timeout_flag_d;
            w_en_q         <= w_en_d;
            r_en_q         <= r_en_d;
            w_addr_q       <= w_addr_d;
            r_addr_q       <= r_addr_d;
            w_data_q       <= w_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (timer_zero) state_d = StIdle;
            StIdle:  if (accept) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (ready_hit || timer_zero) state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        timer_d        = timer_q;
        op_write_d     = op_write_q;
        cmd_ready_d    = OFF;
        rsp_valid_d    = rsp_valid_q;
        rsp_write_d    = rsp_write_q;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        timeout_flag_d = timeout_flag_q;
        w_en_d         = OFF;
        r_en_d         = OFF;
        w_addr_d       = w_addr_q;
        r_addr_d       = r_addr_q;
        w_data_d       = w_data_q;

        unique case (state_q)
            StInit: begin
                if (!timer_zero) timer_d = timer_q - TIMER_ONE;
            end
            StIdle: begin
                if (accept) begin
                    op_write_d = bus.cmd_write;
                    if (bus.cmd_write) begin
                        w_en_d   = ON;
                        w_addr_d = bus.cmd_addr;
                        w_data_d = bus.cmd_wdata;
                    end else begin
                        r_en_d   = ON;
                        r_addr_d = bus.cmd_addr;
                    end
                end else begin
                    cmd_ready_d = ON;
                end
            end
            StIssue: begin
                // Readies are not looked at here, so a w_rdy still high from
                // the previous write cannot complete this command early.
                timer_d = TIMEOUT_LOAD;
            end
            StWait: begin
                if (ready_hit) begin
                    rsp_valid_d = ON;
                    rsp_write_d = op_write_q;
                    rsp_err_d   = OFF;
                    rsp_data_d  = op_write_q ? '0 : bus.r_data;
                end else if (timer_zero) begin
                    rsp_valid_d    = ON;
                    rsp_write_d    = op_write_q;
                    rsp_err_d      = ON;
                    rsp_data_d     = '0;
                    timeout_flag_d = ON;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = OFF;
                    rsp_err_d   = OFF;
                end
            end
            default: ;
        endcase
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_write    = rsp_write_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.w_en         = w_en_q;
    assign bus.r_en         = r_en_q;
    assign bus.w_addr       = w_addr_q;
    assign bus.r_addr       = r_addr_q;
    assign bus.w_data       = w_data_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: a behavioural memory (registered r_rdy pulse,
// level w_rdy cleared on w_en), a table of directed commands with expected
// responses and latencies, and hand-written reset/timeout/backpressure cases.
module tb_mem_initiator;

    localparam int unsigned WS    = 8;
    localparam int unsigned AS    = 4;
    localparam int unsigned INITC = 64;
    localparam int unsigned TMO   = 15;

    logic clock;
    logic reset;
    logic tie_r_rdy;
    int   read_wait;
    int   write_wait;

    int n_vec;
    int n_err;

    mem_initiator_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) bus ();

    mem_initiator #(
        .WORD_SIZE   (WS),
        .ADDRESS_SIZE(AS),
        .INIT_CYCLES (INITC),
        .TIMEOUT     (TMO),
        .TIMER_SIZE  (7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory
    logic [WS-1:0] mem [16];
    logic          rd_busy, wr_busy, m_r_rdy, m_w_rdy;
    int            rd_cnt, wr_cnt;
    logic [AS-1:0] rd_a, wr_a;
    logic [WS-1:0] wr_d, m_r_data;

    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rd_busy  <= 1'b0;
            wr_busy  <= 1'b0;
            m_r_rdy  <= 1'b0;
            m_w_rdy  <= 1'b0;
            rd_cnt   <= 0;
            wr_cnt   <= 0;
            rd_a     <= '0;
            wr_a     <= '0;
            wr_d     <= '0;
            m_r_data <= '0;
        end else begin
            m_r_rdy <= 1'b0;
            if (bus.r_en) begin
                rd_busy <= 1'b1;
                rd_cnt  <= read_wait;
                rd_a    <= bus.r_addr;
            end else if (rd_busy) begin
                if (rd_cnt == 0) begin
                    rd_busy  <= 1'b0;
                    m_r_rdy  <= 1'b1;
                    m_r_data <= mem[rd_a];
                end else begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
            if (bus.w_en) begin
                m_w_rdy <= 1'b0;
                wr_busy <= 1'b1;
                wr_cnt  <= write_wait;
                wr_a    <= bus.w_addr;
                wr_d    <= bus.w_data;
            end else if (wr_busy) begin
                if (wr_cnt == 0) begin
                    wr_busy    <= 1'b0;
                    m_w_rdy    <= 1'b1;
                    mem[wr_a]  <= wr_d;
                end else begin
                    wr_cnt <= wr_cnt - 1;
                end
            end
        end
    end

    assign bus.r_data = m_r_data;
    assign bus.r_rdy  = m_r_rdy & ~tie_r_rdy;
    assign bus.w_rdy  = m_w_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_write"}, 32'(bus.rsp_write), 0);
        check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        check({tag, "_timeout_flag"}, 32'(bus.timeout_flag), 0);
        check({tag, "_en"}, 32'({bus.w_en, bus.r_en}), 0);
        check({tag, "_addr"}, 32'({bus.w_addr, bus.r_addr}), 0);
        check({tag, "_w_data"}, 32'(bus.w_data), 0);
    endtask

    // Called at the negedge right after the last reset edge.
    task automatic wait_init();
        int early = 0;
        for (int k = 1; k <= int'(INITC) + 1; k++) begin
            @(negedge clock);
            if (bus.cmd_ready) early++;
        end
        check("init_ready_low", early, 0);
        @(negedge clock);
        check("init_ready_rise", 32'(bus.cmd_ready), 1);
    endtask

    // Runs one command from a negedge; returns latency in edges from the
    // accepting edge to the first cycle rsp_valid is seen.
    task automatic run_cmd(input logic wr, input logic [AS-1:0] a, input logic [WS-1:0] d,
                           input int hold, output int lat, output logic [WS-1:0] gd,
                           output logic gw, output logic ge);
        int guard = 0;
        int pulses = 0;
        lat = -1; gd = '0; gw = 1'b0; ge = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (bus.cmd_ready !== 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) begin
            check("accept_bound", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        check("en_pulse", 32'(wr ? bus.w_en : bus.r_en), 1);
        check("other_en", 32'(wr ? bus.r_en : bus.w_en), 0);
        check("mem_addr", 32'(wr ? bus.w_addr : bus.r_addr), 32'(a));
        if (wr) check("mem_wdata", 32'(bus.w_data), 32'(d));
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(negedge clock);
            lat++;
            if (bus.w_en || bus.r_en) pulses++;
        end
        check("single_pulse", pulses, 0);
        if (lat >= 100) begin
            check("rsp_bound", 0, 1);
            return;
        end
        gd = bus.rsp_data;
        gw = bus.rsp_write;
        ge = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid", 32'(bus.rsp_valid), 1);
            check("hold_data", 32'(bus.rsp_data), 32'(gd));
            check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clock);
        bus.rsp_ready = 1'b0;
        check("rsp_drop", 32'(bus.rsp_valid), 0);
        check("rsp_err_drop", 32'(bus.rsp_err), 0);
        check("no_reaccept", 32'(bus.cmd_ready), 0);
        @(negedge clock);
        check("cmd_ready_back", 32'(bus.cmd_ready), 1);
        check(wr ? "w_addr_held" : "r_addr_held", 32'(wr ? bus.w_addr : bus.r_addr), 32'(a));
    endtask

    typedef struct {
        logic          wr;
        logic [AS-1:0] addr;
        logic [WS-1:0] wdata;
        logic [WS-1:0] exp_data;
        int            exp_lat;
    } vec_t;

    vec_t vt [7];

    initial begin
        int            lat;
        logic [WS-1:0] gd;
        logic          gw, ge;
        int            guard;

        n_vec = 0;
        n_err = 0;
        read_wait  = 0;
        write_wait = 0;
        tie_r_rdy  = 1'b0;
        reset         = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // write/read latency 3 with zero-wait memory; write data reads back 0
        vt[0] = '{1'b1, 4'd3, 8'hA5, 8'h00, 3};
        vt[1] = '{1'b1, 4'd4, 8'h3C, 8'h00, 3};  // w_rdy still high from previous write
        vt[2] = '{1'b0, 4'd3, 8'h00, 8'hA5, 3};
        vt[3] = '{1'b0, 4'd4, 8'h00, 8'h3C, 3};
        vt[4] = '{1'b1, 4'd15, 8'h5A, 8'h00, 3};
        vt[5] = '{1'b0, 4'd15, 8'h00, 8'h5A, 3};
        vt[6] = '{1'b0, 4'd0, 8'h00, 8'h00, 3};

        // Reset: outputs zero, cmd_valid held high must not be accepted during init
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;
        wait_init();
        bus.cmd_valid = 1'b0;
        @(negedge clock);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_cmd(vt[i].wr, vt[i].addr, vt[i].wdata, 0, lat, gd, gw, ge);
            check($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            check($sformatf("v%0d_data", i), 32'(gd), 32'(vt[i].exp_data));
            check($sformatf("v%0d_write", i), 32'(gw), 32'(vt[i].wr));
            check($sformatf("v%0d_err", i), 32'(ge), 0);
        end

        // Write wait of 2: latency 5 even with stale w_rdy
        write_wait = 2;
        run_cmd(1'b1, 4'd7, 8'h96, 0, lat, gd, gw, ge);
        check("ww2_lat", lat, 5);
        run_cmd(1'b1, 4'd8, 8'h69, 0, lat, gd, gw, ge);
        check("ww2_stale_lat", lat, 5);
        write_wait = 0;

        // Response backpressure for 5 cycles
        run_cmd(1'b0, 4'd3, 8'h00, 5, lat, gd, gw, ge);
        check("bp_lat", lat, 3);
        check("bp_data", 32'(gd), 32'h A5);

        // Read timeout
        check("flag_before", 32'(bus.timeout_flag), 0);
        tie_r_rdy = 1'b1;
        run_cmd(1'b0, 4'd3, 8'h00, 0, lat, gd, gw, ge);
        check("tmo_lat", lat, int'(TMO) + 2);
        check("tmo_err", 32'(ge), 1);
        check("tmo_data", 32'(gd), 0);
        check("tmo_write", 32'(gw), 0);
        check("tmo_flag", 32'(bus.timeout_flag), 1);
        tie_r_rdy = 1'b0;
        run_cmd(1'b1, 4'd5, 8'h77, 0, lat, gd, gw, ge);
        check("post_tmo_werr", 32'(ge), 0);
        run_cmd(1'b0, 4'd5, 8'h00, 0, lat, gd, gw, ge);
        check("post_tmo_rdata", 32'(gd), 32'h77);
        check("post_tmo_rerr", 32'(ge), 0);
        check("flag_sticky", 32'(bus.timeout_flag), 1);

        // Reset while a read sits in WAIT
        tie_r_rdy = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 4'd6;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        check("mid_accept_bound", 32'(guard < 50), 1);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_in_wait", 32'(bus.rsp_valid), 0);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("midrst");
        @(negedge clock);
        reset = 1'b1;
        tie_r_rdy = 1'b0;
        wait_init();
        run_cmd(1'b1, 4'd9, 8'hC3, 0, lat, gd, gw, ge);
        check("after_rst_wlat", lat, 3);
        run_cmd(1'b0, 4'd9, 8'h00, 0, lat, gd, gw, ge);
        check("after_rst_rdata", 32'(gd), 32'h C3);
        check("after_rst_flag", 32'(bus.timeout_flag), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
